// File: rtl/tt_uart_rx.sv
// tt_uart_rx: console UART receiver. The serial line and the baud tick are
// synchronised into the clk domain. An 8N1 frame is deserialised into a
// one-byte holding register, which the consumer empties through a four-phase
// rx_req/rx_ack handshake.
//
// Handshake semantics (consumer-driven, four phase):
//   rx_req rises -> once a byte is held, rx_ack rises one clk later with
//   rx_data valid -> rx_req falls -> rx_ack falls one clk later, the holding
//   register is marked empty and the sticky error flags clear. rx_data keeps
//   its value after rx_ack falls.
module tt_uart_rx #(
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx_clk,
  input  logic                 rx_in,
  input  logic                 rx_req,
  output logic                 rx_ack,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_empty,
  output logic                 rx_frame_err,
  output logic                 rx_overrun,
  output logic [2:0]           rx_state
);

  localparam int CNT_W  = $clog2(OVERSAMPLE);
  localparam int BCNT_W = $clog2(DATA_BITS + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(OVERSAMPLE - 1);
  localparam logic [CNT_W-1:0]  CNT_MID  = CNT_W'(OVERSAMPLE / 2 - 1);
  localparam logic [BCNT_W-1:0] BIT_LAST = BCNT_W'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } state_t;

  state_t                state, state_n;
  logic [CNT_W-1:0]      cnt, cnt_n;
  logic [BCNT_W-1:0]     bcnt, bcnt_n;
  logic [DATA_BITS-1:0]  shift, shift_n;
  logic [DATA_BITS-1:0]  hold;
  logic                  in_s1, in_s2;
  logic                  clk_s1, clk_s2, clk_prev;
  logic                  tick, line;
  logic                  frame_good, frame_bad;
  logic                  ack_rise, ack_fall;

  assign rx_state = state;
  assign line     = in_s2;
  assign tick     = clk_s2 & ~clk_prev;
  assign ack_rise = rx_req & ~rx_empty & ~rx_ack;
  assign ack_fall = rx_ack & ~rx_req;

  // Two-flop synchronisers for the line and the baud clock, plus edge detect.
  always_ff @(posedge clk) begin
    if (reset) begin
      in_s1    <= 1'b1;
      in_s2    <= 1'b1;
      clk_s1   <= 1'b0;
      clk_s2   <= 1'b0;
      clk_prev <= 1'b0;
    end else begin
      in_s1    <= rx_in;
      in_s2    <= in_s1;
      clk_s1   <= rx_clk;
      clk_s2   <= clk_s1;
      clk_prev <= clk_s2;
    end
  end

  // Receive FSM state and counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      bcnt  <= '0;
      shift <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      bcnt  <= bcnt_n;
      shift <= shift_n;
    end
  end

  // Next-state logic; everything advances only on a baud tick.
  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    bcnt_n     = bcnt;
    shift_n    = shift;
    frame_good = 1'b0;
    frame_bad  = 1'b0;
    if (tick) begin
      case (state)
        IDLE: begin
          if (!line) begin
            state_n = START;
            cnt_n   = '0;
          end
        end
        START: begin
          if (cnt == CNT_MID) begin
            if (line) begin
              state_n = IDLE;   // glitch shorter than half a bit
            end else begin
              state_n = DATA;
              cnt_n   = '0;
              bcnt_n  = '0;
            end
          end else begin
            cnt_n = cnt + CNT_W'(1);
          end
        end
        DATA: begin
          if (cnt == CNT_LAST) begin
            shift_n = {line, shift[DATA_BITS-1:1]};
            cnt_n   = '0;
            bcnt_n  = bcnt + BCNT_W'(1);
            if (bcnt == BIT_LAST) state_n = STOP;
          end else begin
            cnt_n = cnt + CNT_W'(1);
          end
        end
        STOP: begin
          if (cnt == CNT_LAST) begin
            cnt_n = '0;
            if (line) begin
              frame_good = 1'b1;
              state_n    = IDLE;
            end else begin
              frame_bad = 1'b1;
              state_n   = BREAK;
            end
          end else begin
            cnt_n = cnt + CNT_W'(1);
          end
        end
        BREAK: begin
          if (line) state_n = IDLE;   // wait out a held-low line
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // Holding register, handshake and sticky error flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      hold         <= '0;
      rx_data      <= '0;
      rx_ack       <= 1'b0;
      rx_empty     <= 1'b1;
      rx_frame_err <= 1'b0;
      rx_overrun   <= 1'b0;
    end else begin
      if (ack_rise) begin
        rx_data <= hold;
        rx_ack  <= 1'b1;
      end else if (ack_fall) begin
        rx_ack <= 1'b0;
      end
      if (ack_fall) begin
        rx_frame_err <= 1'b0;
        rx_overrun   <= 1'b0;
      end
      if (frame_bad) rx_frame_err <= 1'b1;
      if (frame_good) begin
        // A byte landing as the handshake frees the register is accepted.
        if (rx_empty || ack_fall) begin
          hold     <= shift;
          rx_empty <= 1'b0;
        end else begin
          rx_overrun <= 1'b1;
        end
      end else if (ack_fall) begin
        rx_empty <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_tt_uart_rx.sv
// tb_tt_uart_rx: directed and randomised frames against a byte-level model
// of the receiver's holding register and error flags.
module tb_tt_uart_rx;

  logic       clk, reset, rx_clk, rx_in, rx_req;
  logic       rx_ack, rx_empty, rx_frame_err, rx_overrun;
  logic [7:0] rx_data;
  logic [2:0] rx_state;

  int checks = 0;
  int errors = 0;

  // Byte-level model of the receiver's visible state.
  logic       m_full, m_ferr, m_ovr;
  logic [7:0] m_hold;

  tt_uart_rx #(.OVERSAMPLE(16), .DATA_BITS(8)) dut (
    .clk(clk), .reset(reset), .rx_clk(rx_clk), .rx_in(rx_in),
    .rx_req(rx_req), .rx_ack(rx_ack), .rx_data(rx_data),
    .rx_empty(rx_empty), .rx_frame_err(rx_frame_err),
    .rx_overrun(rx_overrun), .rx_state(rx_state)
  );

  // clk period 10; rx_clk period 80, rising on clk negedges.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end
  initial begin
    rx_clk = 1'b0;
    #10;
    forever #40 rx_clk = ~rx_clk;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    m_full = 1'b0; m_ferr = 1'b0; m_ovr = 1'b0; m_hold = 8'h00;
  endtask

  task automatic model_frame(input logic [7:0] b, input logic stop_ok);
    if (!stop_ok) m_ferr = 1'b1;
    else if (m_full) m_ovr = 1'b1;
    else begin
      m_full = 1'b1;
      m_hold = b;
    end
  endtask

  task automatic check_status(input string tag);
    check({tag, ".empty"}, {31'd0, rx_empty}, {31'd0, ~m_full});
    check({tag, ".ferr"}, {31'd0, rx_frame_err}, {31'd0, m_ferr});
    check({tag, ".ovr"}, {31'd0, rx_overrun}, {31'd0, m_ovr});
  endtask

  task automatic idle(input int n);
    rx_in = 1'b1;
    repeat (n) @(posedge rx_clk);
  endtask

  // Drive one frame, one tick per loop. drop_tick lowers rx_req just before
  // the clk that acts on that tick; abort_tick pulses reset instead.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit,
                            input int drop_tick, input int abort_tick);
    logic [9:0] bits;
    bits = {stop_bit, b, 1'b0};
    for (int k = 0; k < 160; k++) begin
      @(posedge rx_clk);
      rx_in = bits[k/16];
      if (k == abort_tick) begin
        #10 reset = 1'b1;
        @(posedge clk); #1;
        check("rst.ack", {31'd0, rx_ack}, 32'd0);
        check("rst.data", {24'd0, rx_data}, 32'd0);
        check("rst.empty", {31'd0, rx_empty}, 32'd1);
        check("rst.ferr", {31'd0, rx_frame_err}, 32'd0);
        check("rst.ovr", {31'd0, rx_overrun}, 32'd0);
        reset = 1'b0;
        rx_in = 1'b1;
        model_clear();
        return;
      end
      if (k == drop_tick) begin
        #20 rx_req = 1'b0;
      end
    end
    if (abort_tick < 0) model_frame(b, stop_bit);
  endtask

  task automatic handshake(input logic [7:0] exp);
    @(negedge clk) rx_req = 1'b1;
    @(posedge clk); #1;
    check("hs.ack_rise", {31'd0, rx_ack}, 32'd1);
    check("hs.data", {24'd0, rx_data}, {24'd0, exp});
    @(negedge clk) rx_req = 1'b0;
    @(posedge clk); #1;
    model_clear();
    check("hs.ack_fall", {31'd0, rx_ack}, 32'd0);
    check("hs.data_hold", {24'd0, rx_data}, {24'd0, exp});
    check_status("hs");
  endtask

  initial begin
    logic [7:0] rb;
    reset = 1'b1; rx_in = 1'b1; rx_req = 1'b0;
    model_clear();
    repeat (4) @(posedge clk);
    #1;
    check("por.ack", {31'd0, rx_ack}, 32'd0);
    check("por.data", {24'd0, rx_data}, 32'd0);
    check_status("por");
    reset = 1'b0;
    idle(20);

    // Basic frame and handshake.
    send_frame(8'h41, 1'b1, -1, -1);
    check_status("f41");
    handshake(8'h41);

    // Short low glitch, then a real frame.
    @(posedge rx_clk); rx_in = 1'b0;
    repeat (3) @(posedge rx_clk);
    idle(24);
    check_status("glitch");
    send_frame(8'h7F, 1'b1, -1, -1);
    check_status("f7f");
    handshake(8'h7F);

    // Framing error, held-low break, recovery.
    idle(10);
    send_frame(8'h55, 1'b0, -1, -1);
    check_status("ferr");
    rx_in = 1'b0;
    repeat (40) @(posedge rx_clk);
    check_status("break");
    idle(20);
    send_frame(8'h33, 1'b1, -1, -1);
    check_status("f33");
    handshake(8'h33);

    // Overrun: the older byte is kept.
    idle(8);
    send_frame(8'h12, 1'b1, -1, -1);
    idle(5);
    send_frame(8'h34, 1'b1, -1, -1);
    check_status("ovr");
    handshake(8'h12);

    // Request while empty waits for the byte.
    @(negedge clk) rx_req = 1'b1;
    repeat (5) @(posedge clk);
    #1 check("req_empty.ack", {31'd0, rx_ack}, 32'd0);
    send_frame(8'hC3, 1'b1, -1, -1);
    check("req_wait.ack", {31'd0, rx_ack}, 32'd1);
    check("req_wait.data", {24'd0, rx_data}, 32'hC3);
    @(negedge clk) rx_req = 1'b0;
    @(posedge clk); #1;
    model_clear();
    check("req_wait.fall", {31'd0, rx_ack}, 32'd0);
    check_status("req_wait");

    // Stop sample coincides with rx_ack falling for the previous byte.
    idle(6);
    send_frame(8'hAA, 1'b1, -1, -1);
    @(negedge clk) rx_req = 1'b1;
    @(posedge clk); #1;
    check("coin.ack", {31'd0, rx_ack}, 32'd1);
    check("coin.data", {24'd0, rx_data}, 32'hAA);
    idle(5);
    m_full = 1'b0;   // ack fall frees the register in the same clk
    send_frame(8'h56, 1'b1, 152, -1);
    check("coin.ack_low", {31'd0, rx_ack}, 32'd0);
    check_status("coin");
    handshake(8'h56);

    // Reset mid-frame discards both the partial and the held byte.
    idle(4);
    send_frame(8'hE7, 1'b1, -1, -1);
    idle(4);
    send_frame(8'h99, 1'b1, -1, 72);
    idle(20);
    send_frame(8'h0D, 1'b1, -1, -1);
    check_status("f0d");
    handshake(8'h0D);

    // Randomised bytes, gaps and occasional skipped handshakes.
    for (int i = 0; i < 6; i++) begin
      rb = 8'($urandom_range(0, 255));
      idle($urandom_range(1, 30));
      send_frame(rb, 1'b1, -1, -1);
      check_status("rnd");
      if (m_full && ($urandom_range(0, 3) != 0)) handshake(m_hold);
    end
    if (m_full) handshake(m_hold);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
